// File: rtl/lcd_ctrl.sv
// 8x8 greyscale image controller: loads IROM into a buffer, edits a 2x2 block, dumps to IRB.
// Define LCD_CTRL_AVG_ROUND_EN to make the average round half-up instead of truncating.
`timescale 1ns/1ps
module lcd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IROM_Q,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    output logic       IROM_EN,
    output logic [5:0] IROM_A,
    output logic       IRB_RW,
    output logic [7:0] IRB_D,
    output logic [5:0] IRB_A,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state;
    logic [2:0] px;
    logic [2:0] py;
    logic [2:0] cmd_p0;
    logic [7:0] buffer [64];

    logic [2:0] pxm;
    logic [2:0] pym;
    logic [5:0] a00;
    logic [5:0] a01;
    logic [5:0] a10;
    logic [5:0] a11;
    logic [7:0] blk_avg;

    function automatic logic [7:0] avg4(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3);
        logic [9:0] sum;
        sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
`ifdef LCD_CTRL_AVG_ROUND_EN
        sum = sum + 10'd2;
`endif
        avg4 = sum[9:2];
    endfunction

    // Block corners: row-major address is {y, x} since the image is 8 wide.
    assign pxm     = px - 3'd1;
    assign pym     = py - 3'd1;
    assign a00     = {pym, pxm};
    assign a01     = {pym, px};
    assign a10     = {py,  pxm};
    assign a11     = {py,  px};
    assign blk_avg = avg4(buffer[a00], buffer[a01], buffer[a10], buffer[a11]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_LOAD;
            busy    <= 1'b1;
            done    <= 1'b0;
            IROM_EN <= 1'b1;
            IROM_A  <= 6'd0;
            IRB_RW  <= 1'b1;
            IRB_A   <= 6'd0;
            IRB_D   <= 8'd0;
            px      <= 3'd4;
            py      <= 3'd4;
            cmd_p0  <= 3'd0;
        end else begin
            case (state)
                // IROM_EN high on entry marks the first cycle, before any address is issued.
                S_LOAD: begin
                    if (IROM_EN) begin
                        IROM_EN <= 1'b0;
                    end else if (IROM_A == 6'd63) begin
                        IROM_EN <= 1'b1;
                        IROM_A  <= 6'd0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        IROM_A <= IROM_A + 6'd1;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_p0 <= cmd;
                        busy   <= 1'b1;
                        if (cmd == 3'd0) begin
                            IRB_RW <= 1'b0;
                            IRB_A  <= 6'd0;
                            IRB_D  <= buffer[0];
                            state  <= S_WRITE;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    case (cmd_p0)
                        3'd1: if (py > 3'd1) py <= py - 3'd1;
                        3'd2: if (py < 3'd7) py <= py + 3'd1;
                        3'd3: if (px > 3'd1) px <= px - 3'd1;
                        3'd4: if (px < 3'd7) px <= px + 3'd1;
                        default: ;
                    endcase
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_WRITE: begin
                    if (IRB_A == 6'd63) begin
                        IRB_RW <= 1'b1;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        IRB_A <= IRB_A + 6'd1;
                        IRB_D <= buffer[IRB_A + 6'd1];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // Pixel storage carries no reset; LOAD always overwrites every entry.
    always_ff @(posedge clk) begin
        case (state)
            S_LOAD: begin
                if (!IROM_EN) buffer[IROM_A] <= IROM_Q;
            end
            S_EXEC: begin
                case (cmd_p0)
                    3'd5: begin
                        buffer[a00] <= blk_avg;
                        buffer[a01] <= blk_avg;
                        buffer[a10] <= blk_avg;
                        buffer[a11] <= blk_avg;
                    end
                    3'd6: begin
                        buffer[a00] <= buffer[a10];
                        buffer[a10] <= buffer[a00];
                        buffer[a01] <= buffer[a11];
                        buffer[a11] <= buffer[a01];
                    end
                    3'd7: begin
                        buffer[a00] <= buffer[a01];
                        buffer[a01] <= buffer[a00];
                        buffer[a10] <= buffer[a11];
                        buffer[a11] <= buffer[a10];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with IROM/IRB memory models and an image-level reference model.
`timescale 1ns/1ps
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] IROM_Q = 8'd0;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic       IROM_EN;
    logic [5:0] IROM_A;
    logic       IRB_RW;
    logic [7:0] IRB_D;
    logic [5:0] IRB_A;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [64];
    logic [7:0] irb [64];
    int         irb_writes = 0;
    int         img [8][8];
    int         px;
    int         py;

    lcd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .IROM_Q    (IROM_Q),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_EN   (IROM_EN),
        .IROM_A    (IROM_A),
        .IRB_RW    (IRB_RW),
        .IRB_D     (IRB_D),
        .IRB_A     (IRB_A),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!IROM_EN) IROM_Q <= rom[IROM_A];

    always @(negedge clk) begin
        if (!IRB_RW) begin
            irb[IRB_A] = IRB_D;
            irb_writes = irb_writes + 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1);
    end

    function automatic void model_reset();
        for (int a = 0; a < 64; a++) img[a / 8][a % 8] = int'(rom[a]);
        px = 4;
        py = 4;
    endfunction

    function automatic void model_cmd(input int c);
        int s;
        int t;
        case (c)
            1: if (py > 1) py--;
            2: if (py < 7) py++;
            3: if (px > 1) px--;
            4: if (px < 7) px++;
            5: begin
                s = img[py-1][px-1] + img[py-1][px] + img[py][px-1] + img[py][px];
`ifdef LCD_CTRL_AVG_ROUND_EN
                s = (s + 2) / 4;
`else
                s = s / 4;
`endif
                img[py-1][px-1] = s; img[py-1][px] = s;
                img[py][px-1]   = s; img[py][px]   = s;
            end
            6: begin
                t = img[py-1][px-1]; img[py-1][px-1] = img[py][px-1]; img[py][px-1] = t;
                t = img[py-1][px];   img[py-1][px]   = img[py][px];   img[py][px]   = t;
            end
            7: begin
                t = img[py-1][px-1]; img[py-1][px-1] = img[py-1][px]; img[py-1][px] = t;
                t = img[py][px-1];   img[py][px-1]   = img[py][px];   img[py][px]   = t;
            end
            default: ;
        endcase
    endfunction

    function automatic int irb_first_diff();
        logic [7:0] e;
        for (int a = 0; a < 64; a++) begin
            e = 8'(img[a / 8][a % 8]);
            if (irb[a] !== e) return a;
        end
        return -1;
    endfunction

    task automatic clear_irb();
        for (int a = 0; a < 64; a++) irb[a] = 8'hee;
        irb_writes = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_load(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue(input logic [2:0] c, output int bcyc, output int dn, output bit ok);
        bcyc = 0;
        dn   = 0;
        ok   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        cmd       = c;
        cmd_valid = 1'b1;
        model_cmd(int'(c));
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) dn++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        for (int a = 0; a < 64; a++) rom[a] = 8'(a);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (IROM_EN !== 1'b1) begin errors++; $display("FAIL reset_irom_en got %b want 1", IROM_EN); end
        checks++; if (IRB_RW !== 1'b1)  begin errors++; $display("FAIL reset_irb_rw got %b want 1", IRB_RW); end
        checks++; if (IROM_A !== 6'd0)  begin errors++; $display("FAIL reset_irom_a got %0d want 0", IROM_A); end
        checks++; if (IRB_A !== 6'd0)   begin errors++; $display("FAIL reset_irb_a got %0d want 0", IRB_A); end
        checks++; if (IRB_D !== 8'd0)   begin errors++; $display("FAIL reset_irb_d got %0d want 0", IRB_D); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_load(cyc, ok);
        checks++;
        if (!ok || cyc < 64 || cyc > 66) begin
            errors++; $display("FAIL load_time got %0d cycles (ok=%0b) want 64..66", cyc, ok);
        end
        checks++; if (IROM_EN !== 1'b1) begin errors++; $display("FAIL load_irom_en_idle got %b want 1", IROM_EN); end
    endtask

    task automatic test_write_identity();
        int bcyc, dn, d;
        bit ok;
        clear_irb();
        issue(3'd0, bcyc, dn, ok);
        checks++; if (!ok)     begin errors++; $display("FAIL write_busy_release got timeout want busy low"); end
        checks++; if (dn != 1) begin errors++; $display("FAIL write_done_pulses got %0d want 1", dn); end
        checks++; if (irb_writes != 64) begin errors++; $display("FAIL write_count got %0d want 64", irb_writes); end
        d = irb_first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL write_identity addr %0d got %0d want %0d", d, irb[d], img[d/8][d%8]); end
    endtask

    task automatic test_average();
        int bcyc, dn, d;
        bit ok;
        logic [7:0] want;
        int addrs [4] = '{27, 28, 35, 36};
`ifdef LCD_CTRL_AVG_ROUND_EN
        want = 8'd32;
`else
        want = 8'd31;
`endif
        issue(3'd5, bcyc, dn, ok);
        checks++; if (!ok || bcyc != 1) begin errors++; $display("FAIL avg_busy_cycles got %0d want 1", bcyc); end
        issue(3'd0, bcyc, dn, ok);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (irb[addrs[i]] !== want) begin
                errors++; $display("FAIL avg_pixel addr %0d got %0d want %0d", addrs[i], irb[addrs[i]], want);
            end
        end
        d = irb_first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL avg_image addr %0d got %0d want %0d", d, irb[d], img[d/8][d%8]); end
    endtask

    task automatic test_clamp_mirror_y();
        int bcyc, dn, d;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            issue(3'd1, bcyc, dn, ok);
            checks++; if (!ok || bcyc != 1) begin errors++; $display("FAIL shift_up_cycles step %0d got %0d want 1", i, bcyc); end
        end
        for (int i = 0; i < 4; i++) begin
            issue(3'd3, bcyc, dn, ok);
            checks++; if (!ok || bcyc != 1) begin errors++; $display("FAIL shift_left_cycles step %0d got %0d want 1", i, bcyc); end
        end
        issue(3'd7, bcyc, dn, ok);
        issue(3'd0, bcyc, dn, ok);
        checks++; if (irb[0] !== 8'd1) begin errors++; $display("FAIL mirror_y_0 got %0d want 1", irb[0]); end
        checks++; if (irb[1] !== 8'd0) begin errors++; $display("FAIL mirror_y_1 got %0d want 0", irb[1]); end
        checks++; if (irb[8] !== 8'd9) begin errors++; $display("FAIL mirror_y_8 got %0d want 9", irb[8]); end
        checks++; if (irb[9] !== 8'd8) begin errors++; $display("FAIL mirror_y_9 got %0d want 8", irb[9]); end
        d = irb_first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL mirror_y_image addr %0d got %0d want %0d", d, irb[d], img[d/8][d%8]); end
    endtask

    task automatic test_clamp_mirror_x();
        int bcyc, dn, d, cyc;
        bit ok;
        pulse_reset();
        wait_load(cyc, ok);
        for (int i = 0; i < 5; i++) begin
            issue(3'd2, bcyc, dn, ok);
            checks++; if (!ok || bcyc != 1) begin errors++; $display("FAIL shift_down_cycles step %0d got %0d want 1", i, bcyc); end
        end
        for (int i = 0; i < 5; i++) begin
            issue(3'd4, bcyc, dn, ok);
            checks++; if (!ok || bcyc != 1) begin errors++; $display("FAIL shift_right_cycles step %0d got %0d want 1", i, bcyc); end
        end
        issue(3'd6, bcyc, dn, ok);
        issue(3'd0, bcyc, dn, ok);
        checks++; if (irb[54] !== 8'd62) begin errors++; $display("FAIL mirror_x_54 got %0d want 62", irb[54]); end
        checks++; if (irb[62] !== 8'd54) begin errors++; $display("FAIL mirror_x_62 got %0d want 54", irb[62]); end
        checks++; if (irb[55] !== 8'd63) begin errors++; $display("FAIL mirror_x_55 got %0d want 63", irb[55]); end
        checks++; if (irb[63] !== 8'd55) begin errors++; $display("FAIL mirror_x_63 got %0d want 55", irb[63]); end
        d = irb_first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL mirror_x_image addr %0d got %0d want %0d", d, irb[d], img[d/8][d%8]); end
    endtask

    task automatic test_cmd_valid_held();
        int seq [16];
        int cyc, dn, d;
        bit ok;
        for (int a = 0; a < 64; a++) rom[a] = 8'($urandom_range(0, 255));
        seq[0] = 4;
        for (int n = 1; n < 16; n++) seq[n] = int'($urandom_range(0, 7));
        seq[8]  = 0;
        seq[15] = 0;
        clear_irb();
        @(negedge clk);
        cmd       = 3'd4;
        cmd_valid = 1'b1;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_cmd(seq[0]);
        wait_load(cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL held_load got timeout want busy low"); end
        for (int n = 0; n < 16; n++) begin
            cyc = 0;
            dn  = 0;
            ok  = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                cyc++;
                if (done) dn++;
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (seq[n] == 0) begin
                d = irb_first_diff();
                checks++;
                if (!ok || dn != 1 || d != -1) begin
                    errors++; $display("FAIL held_write step %0d done_pulses %0d diff_addr %0d want 1 and -1", n, dn, d);
                end
            end else begin
                checks++;
                if (!ok || cyc != 2) begin
                    errors++; $display("FAIL held_exec step %0d cmd %0d got %0d negedges want 2", n, seq[n], cyc);
                end
            end
            if (n < 15) begin
                cmd = 3'(seq[n + 1]);
                model_cmd(seq[n + 1]);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int bcyc, dn, d, cyc;
        bit ok, found;
        clear_irb();
        @(negedge clk);
        cmd       = 3'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!IRB_RW && IRB_A == 6'd20) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_k20 got timeout want IRB_A=20"); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (IRB_RW !== 1'b1) begin errors++; $display("FAIL abort_irb_rw got %b want 1", IRB_RW); end
        checks++; if (IRB_A !== 6'd0)  begin errors++; $display("FAIL abort_irb_a got %0d want 0", IRB_A); end
        checks++; if (IRB_D !== 8'd0)  begin errors++; $display("FAIL abort_irb_d got %0d want 0", IRB_D); end
        checks++; if (IROM_EN !== 1'b1) begin errors++; $display("FAIL abort_irom_en got %b want 1", IROM_EN); end
        checks++; if (irb_writes != 21) begin errors++; $display("FAIL abort_write_count got %0d want 21", irb_writes); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        dn = 0;
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (done) dn++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || dn != 0 || cyc < 64 || cyc > 66) begin
            errors++; $display("FAIL abort_reload done_pulses %0d cycles %0d want 0 and 64..66", dn, cyc);
        end
        issue(3'd0, bcyc, dn, ok);
        d = irb_first_diff();
        checks++;
        if (!ok || dn != 1 || d != -1) begin
            errors++; $display("FAIL abort_rewrite done_pulses %0d diff_addr %0d want 1 and -1", dn, d);
        end
    endtask

    task automatic test_random();
        int bcyc, dn, d, cyc;
        bit ok;
        logic [2:0] c;
        for (int a = 0; a < 64; a++) rom[a] = 8'($urandom_range(0, 255));
        pulse_reset();
        wait_load(cyc, ok);
        for (int r = 0; r < 40; r++) begin
            c = 3'($urandom_range(1, 7));
            issue(c, bcyc, dn, ok);
            checks++;
            if (!ok || bcyc != 1 || dn != 0) begin
                errors++; $display("FAIL rand_exec step %0d cmd %0d busy_cycles %0d done %0d want 1 and 0", r, c, bcyc, dn);
            end
            if (r % 10 == 9) begin
                issue(3'd0, bcyc, dn, ok);
                d = irb_first_diff();
                checks++;
                if (!ok || dn != 1 || d != -1) begin
                    errors++; $display("FAIL rand_write step %0d done_pulses %0d diff_addr %0d want 1 and -1", r, dn, d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_identity();
        test_average();
        test_clamp_mirror_y();
        test_clamp_mirror_x();
        test_cmd_valid_held();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
